// File: rtl/clock_set_ctrl_if.sv
// Front-panel bundle between the board buttons/switch and the clock counter.
//   btn_mode, btn_inc : raw push-buttons, asynchronous, active-high
//   run_sw            : user run switch
//   en, hrup, minup   : controls for the clock counter
//   mode              : 00 RUN, 01 SET_HR, 10 SET_MIN
//   blink             : display flash flag for the field being set
// The controller uses the slave modport; the panel/board side uses master.
interface clock_set_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       run_sw;
  logic       en;
  logic       hrup;
  logic       minup;
  logic [1:0] mode;
  logic       blink;

  modport slave (
    input  btn_mode, btn_inc, run_sw,
    output en, hrup, minup, mode, blink
  );

  modport master (
    output btn_mode, btn_inc, run_sw,
    input  en, hrup, minup, mode, blink
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Front-panel controller for the digital clock. Conditions two raw buttons
// (2-FF sync + debounce), runs the RUN / SET_HR / SET_MIN mode FSM, emits
// single-cycle hrup/minup pulses with auto-repeat, gates the clock enable and
// drives a blink flag for the field being set.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   pnl_if : front-panel bundle (buttons and run switch in; en, hrup, minup,
//            mode, blink out), all outputs registered
//
// state      | meaning
// ST_RUN     | clock runs when run_sw=1, inc presses ignored
// ST_SET_HR  | clock frozen, inc pulses hrup, idle timeout armed
// ST_SET_MIN | clock frozen, inc pulses minup, idle timeout armed
module clock_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYC     = 1_000_000,
  parameter int unsigned REPEAT_DELAY_CYC = 50_000_000,
  parameter int unsigned REPEAT_RATE_CYC  = 10_000_000,
  parameter int unsigned TIMEOUT_CYC      = 1_500_000_000,
  parameter int unsigned BLINK_CYC        = 25_000_000
) (
  input logic             clk,
  input logic             rst_n,
  clock_set_ctrl_if.slave pnl_if
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned RP_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                                   REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int unsigned RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;
  localparam int unsigned TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned BL_W   = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  localparam logic [DB_W-1:0] DB_TC      = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [RP_W-1:0] RP_DLY_TC  = RP_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [RP_W-1:0] RP_RATE_TC = RP_W'(REPEAT_RATE_CYC - 1);
  localparam logic [TO_W-1:0] TO_TC      = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [BL_W-1:0] BL_TC      = BL_W'(BLINK_CYC - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10
  } state_t;

  // Button index 0 = mode, 1 = inc.
  logic [1:0]           btn_raw;
  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           db_q, db_d;
  logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]           arm_q, arm_d;
  logic [1:0]           vld_q;
  logic [1:0]           press;

  state_t          state_q, state_d;
  logic            state_chg;
  logic [TO_W-1:0] idle_q, idle_d;

  logic            rep_act_q, rep_act_d;
  logic            rep_rate_q, rep_rate_d;
  logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic            rep_hit;

  logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
  logic            blink_q, blink_d;

  logic en_q, en_d;
  logic hrup_q, hrup_d;
  logic minup_q, minup_d;

  logic mode_press, inc_press, in_set, inc_take, rep_fire, pulse;

  assign btn_raw = {pnl_if.btn_inc, pnl_if.btn_mode};

  // Debounce. A button only produces a press once it has been seen released
  // after reset (arm), so a button held through reset never counts as a press
  // even though its debounced level still rises from 0. vld_q marks when the
  // synchroniser output reflects post-reset samples.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    arm_d    = arm_q;
    press    = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_TC) begin
          db_d[i]     = sync2_q[i];
          db_cnt_d[i] = '0;
          press[i]    = sync2_q[i] & arm_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end else begin
        db_cnt_d[i] = '0;
      end
      if (vld_q[1] && !sync2_q[i]) begin
        arm_d[i] = 1'b1;
      end
    end
  end

  assign mode_press = press[0];
  assign inc_press  = press[1];
  assign in_set     = (state_q != ST_RUN);

  // Mode FSM: a mode press has priority over the idle timeout.
  always_comb begin
    state_d = state_q;
    if (mode_press) begin
      unique case (state_q)
        ST_RUN:     state_d = ST_SET_HR;
        ST_SET_HR:  state_d = ST_SET_MIN;
        ST_SET_MIN: state_d = ST_RUN;
        default:    state_d = ST_RUN;
      endcase
    end else if (in_set && (idle_q == TO_TC)) begin
      state_d = ST_RUN;
    end
  end

  assign state_chg = (state_d != state_q);

  always_comb begin
    idle_d = idle_q + TO_W'(1);
    if (!in_set || state_chg || mode_press || inc_press) begin
      idle_d = '0;
    end
  end

  // Pulses are suppressed on the cycle the state changes, so a pulse never
  // lands in RUN and a mode+inc coincidence drops the inc.
  assign inc_take = inc_press & in_set & ~state_chg;
  assign rep_hit  = rep_rate_q ? (rep_cnt_q == RP_RATE_TC) : (rep_cnt_q == RP_DLY_TC);
  assign rep_fire = rep_act_q & db_q[1] & rep_hit & in_set & ~state_chg;
  assign pulse    = inc_take | rep_fire;

  // The press strobe coincides with db_q still low, so the press is handled
  // before the release check.
  always_comb begin
    rep_act_d  = rep_act_q;
    rep_rate_d = rep_rate_q;
    rep_cnt_d  = rep_cnt_q;
    if (state_chg) begin
      rep_act_d  = 1'b0;
      rep_rate_d = 1'b0;
      rep_cnt_d  = '0;
    end else if (inc_take) begin
      rep_act_d  = 1'b1;
      rep_rate_d = 1'b0;
      rep_cnt_d  = '0;
    end else if (!db_q[1]) begin
      rep_act_d  = 1'b0;
      rep_rate_d = 1'b0;
      rep_cnt_d  = '0;
    end else if (rep_act_q) begin
      if (rep_hit) begin
        rep_rate_d = 1'b1;
        rep_cnt_d  = '0;
      end else begin
        rep_cnt_d  = rep_cnt_q + RP_W'(1);
      end
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (state_chg) begin
      blink_cnt_d = '0;
      blink_d     = (state_d != ST_RUN);
    end else if (!in_set) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (blink_cnt_q == BL_TC) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BL_W'(1);
    end
  end

  always_comb begin
    en_d    = pnl_if.run_sw & (state_q == ST_RUN);
    hrup_d  = pulse & (state_q == ST_SET_HR);
    minup_d = pulse & (state_q == ST_SET_MIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      vld_q       <= '0;
      db_q        <= '0;
      db_cnt_q    <= '0;
      arm_q       <= '0;
      state_q     <= ST_RUN;
      idle_q      <= '0;
      rep_act_q   <= 1'b0;
      rep_rate_q  <= 1'b0;
      rep_cnt_q   <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      en_q        <= 1'b0;
      hrup_q      <= 1'b0;
      minup_q     <= 1'b0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      vld_q       <= {vld_q[0], 1'b1};
      db_q        <= db_d;
      db_cnt_q    <= db_cnt_d;
      arm_q       <= arm_d;
      state_q     <= state_d;
      idle_q      <= idle_d;
      rep_act_q   <= rep_act_d;
      rep_rate_q  <= rep_rate_d;
      rep_cnt_q   <= rep_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      en_q        <= en_d;
      hrup_q      <= hrup_d;
      minup_q     <= minup_d;
    end
  end

  assign pnl_if.en    = en_q;
  assign pnl_if.hrup  = hrup_q;
  assign pnl_if.minup = minup_q;
  assign pnl_if.mode  = state_q;
  assign pnl_if.blink = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl with short timer parameters.
// Expected hrup/minup pulses (edge index + kind) are queued when the button
// stimulus is driven and popped by a negedge monitor when a pulse appears.
module tb_clock_set_ctrl;
  localparam int unsigned DEB   = 4;
  localparam int unsigned RDLY  = 20;
  localparam int unsigned RRATE = 5;
  localparam int unsigned TMO   = 100;
  localparam int unsigned BLK   = 8;
  // raw button edge -> debounced press edge: 2 sync stages + DEB cycles
  localparam int unsigned LAT   = 2 + DEB;

  localparam logic [1:0] K_HR  = 2'b10;
  localparam logic [1:0] K_MIN = 2'b01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  clock_set_ctrl_if pnl();

  clock_set_ctrl #(
    .DEBOUNCE_CYC    (DEB),
    .REPEAT_DELAY_CYC(RDLY),
    .REPEAT_RATE_CYC (RRATE),
    .TIMEOUT_CYC     (TMO),
    .BLINK_CYC       (BLK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pnl_if(pnl)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    logic [1:0]  kind;
  } exp_t;

  exp_t sb[$];
  exp_t e_pop;
  int   n_vec   = 0;
  int   n_err   = 0;
  int   n_pulse = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int unsigned at, input logic [1:0] kind);
    exp_t e;
    e.at   = at;
    e.kind = kind;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) tick(1);
  endtask

  task automatic press_mode();
    pnl.btn_mode = 1'b1;
    tick(8);
    pnl.btn_mode = 1'b0;
    tick(10);
  endtask

  always @(negedge clk) begin
    if (pnl.hrup || pnl.minup) begin
      n_pulse++;
      if (sb.size() == 0) begin
        chk("spurious_pulse", 32'({pnl.hrup, pnl.minup}), 32'd0);
      end else begin
        e_pop = sb.pop_front();
        chk("pulse_cyc", cyc, e_pop.at);
        chk("pulse_kind", 32'({pnl.hrup, pnl.minup}), 32'(e_pop.kind));
      end
      chk("pulse_en_low", 32'(pnl.en), 32'd0);
      chk("pulse_in_set", 32'(pnl.mode != 2'b00), 32'd1);
    end
  end

  int unsigned e0, ent, p0;
  int          np;

  initial begin
    pnl.btn_mode = 1'b0;
    pnl.btn_inc  = 1'b0;
    pnl.run_sw   = 1'b1;

    // 1: reset values, then en from the first cycle after release
    tick(3);
    chk("rst_mode", 32'(pnl.mode), 32'd0);
    chk("rst_en", 32'(pnl.en), 32'd0);
    chk("rst_blink", 32'(pnl.blink), 32'd0);
    chk("rst_hrup", 32'(pnl.hrup), 32'd0);
    rst_n = 1'b1;
    tick(1);
    chk("t1_en_first", 32'(pnl.en), 32'd1);
    chk("t1_mode", 32'(pnl.mode), 32'd0);
    tick(5);
    chk("t1_en_steady", 32'(pnl.en), 32'd1);
    pnl.run_sw = 1'b0;
    tick(1);
    chk("t1_en_sw_off", 32'(pnl.en), 32'd0);
    pnl.run_sw = 1'b1;
    tick(1);
    chk("t1_en_sw_on", 32'(pnl.en), 32'd1);

    // 2: bounce 1-0-1, then hold 10 cycles
    e0 = cyc;
    pnl.btn_mode = 1'b1;
    tick(2);
    pnl.btn_mode = 1'b0;
    tick(2);
    pnl.btn_mode = 1'b1;
    wait_until(e0 + 4 + LAT - 1);
    chk("t2_mode_before", 32'(pnl.mode), 32'd0);
    wait_until(e0 + 4 + LAT);
    chk("t2_mode_sethr", 32'(pnl.mode), 32'd1);
    chk("t2_en_lag", 32'(pnl.en), 32'd1);
    wait_until(e0 + 4 + LAT + 1);
    chk("t2_en_off", 32'(pnl.en), 32'd0);
    wait_until(e0 + 14);
    pnl.btn_mode = 1'b0;
    tick(15);
    chk("t2_single_step", 32'(pnl.mode), 32'd1);

    // 3: SET_MIN, inc held: press pulse + repeats at +20,+25,+30,+35
    e0 = cyc;
    pnl.btn_mode = 1'b1;
    wait_until(e0 + 8);
    pnl.btn_mode = 1'b0;
    chk("t3_mode_setmin", 32'(pnl.mode), 32'd2);
    tick(12);
    e0 = cyc;
    p0 = e0 + LAT;
    push(p0, K_MIN);
    push(p0 + RDLY, K_MIN);
    push(p0 + RDLY + RRATE, K_MIN);
    push(p0 + RDLY + 2 * RRATE, K_MIN);
    push(p0 + RDLY + 3 * RRATE, K_MIN);
    np = n_pulse;
    pnl.btn_inc = 1'b1;
    wait_until(e0 + 38);
    pnl.btn_inc = 1'b0;
    tick(20);
    chk("t3_pulse_count", 32'(n_pulse - np), 32'd5);
    chk("t3_sb_drained", 32'(sb.size()), 32'd0);

    // 4: mode+inc together in SET_HR -> SET_MIN, no pulses while inc stays held
    press_mode();
    chk("t4_mode_run", 32'(pnl.mode), 32'd0);
    press_mode();
    chk("t4_mode_sethr", 32'(pnl.mode), 32'd1);
    np = n_pulse;
    e0 = cyc;
    pnl.btn_mode = 1'b1;
    pnl.btn_inc  = 1'b1;
    wait_until(e0 + LAT);
    chk("t4_mode_setmin", 32'(pnl.mode), 32'd2);
    wait_until(e0 + 10);
    pnl.btn_mode = 1'b0;
    wait_until(e0 + LAT + 30);
    pnl.btn_inc = 1'b0;
    tick(10);
    chk("t4_no_pulses", 32'(n_pulse - np), 32'd0);
    chk("t4_mode_kept", 32'(pnl.mode), 32'd2);

    // 5: idle timeout from SET_HR, blink behaviour
    press_mode();
    chk("t5_mode_run", 32'(pnl.mode), 32'd0);
    chk("t5_blink_run", 32'(pnl.blink), 32'd0);
    e0 = cyc;
    pnl.btn_mode = 1'b1;
    ent = e0 + LAT;
    wait_until(ent);
    chk("t5_mode_sethr", 32'(pnl.mode), 32'd1);
    chk("t5_blink_entry", 32'(pnl.blink), 32'd1);
    wait_until(e0 + 8);
    pnl.btn_mode = 1'b0;
    wait_until(ent + BLK - 1);
    chk("t5_blink_hold", 32'(pnl.blink), 32'd1);
    wait_until(ent + BLK);
    chk("t5_blink_toggle", 32'(pnl.blink), 32'd0);
    wait_until(ent + 2 * BLK);
    chk("t5_blink_back", 32'(pnl.blink), 32'd1);
    wait_until(ent + TMO - 1);
    chk("t5_mode_pre_tmo", 32'(pnl.mode), 32'd1);
    wait_until(ent + TMO);
    chk("t5_mode_tmo", 32'(pnl.mode), 32'd0);
    chk("t5_blink_tmo", 32'(pnl.blink), 32'd0);
    wait_until(ent + TMO + 1);
    chk("t5_en_back", 32'(pnl.en), 32'd1);

    // 6: reset during auto-repeat, buttons held through reset release
    press_mode();
    chk("t6_mode_sethr", 32'(pnl.mode), 32'd1);
    e0 = cyc;
    p0 = e0 + LAT;
    push(p0, K_HR);
    push(p0 + RDLY, K_HR);
    pnl.btn_inc = 1'b1;
    wait_until(p0 + RDLY + RRATE);
    chk("t6_hrup_before_rst", 32'(pnl.hrup), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_hrup_async", 32'(pnl.hrup), 32'd0);
    chk("t6_minup_async", 32'(pnl.minup), 32'd0);
    chk("t6_en_async", 32'(pnl.en), 32'd0);
    chk("t6_mode_async", 32'(pnl.mode), 32'd0);
    pnl.btn_mode = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    chk("t6_held_no_press", 32'(pnl.mode), 32'd0);
    chk("t6_en_run", 32'(pnl.en), 32'd1);
    pnl.btn_mode = 1'b0;
    pnl.btn_inc  = 1'b0;
    tick(10);
    chk("t6_release_no_press", 32'(pnl.mode), 32'd0);
    press_mode();
    chk("t6_fresh_press", 32'(pnl.mode), 32'd1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
